// File: rtl/popcount_weight_enum.sv
// popcount_weight_enum: emits every WIDTH-bit vector with a given popcount, ascending, one per transfer
module popcount_weight_enum #(
  parameter int WIDTH = 28,
  parameter int CW = 5,
  parameter int IW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    weight,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [WIDTH-1:0] vec_data,
  output logic             vec_last,
  output logic [IW-1:0]    vec_index
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0] index_q, index_d;
  logic err_q, err_d;
  logic [CW-1:0] ctz;
  logic [WIDTH:0] x, c, r, nxt;
  logic unused_carry;
  assign busy = state_q == RUN;
  assign vec_valid = state_q == RUN;
  assign done = state_q == FIN;
  assign err = err_q;
  assign vec_data = data_q;
  assign vec_index = index_q;
  assign vec_last = vec_valid && data_q == ~({WIDTH{1'b1}} >> k_q);
  // Gosper's next combination; the carry into bit WIDTH only appears past the last vector
  always_comb begin
    ctz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (data_q[i]) ctz = CW'(i);
    x = {1'b0, data_q};
    c = x & -x;
    r = x + c;
    nxt = r | (((r ^ x) >> 2) >> ctz);
    unused_carry = nxt[WIDTH];
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    data_d = data_q;
    index_d = index_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        err_d = weight > CW'(WIDTH);
        state_d = err_d ? FIN : RUN;
        if (!err_d) begin
          k_d = weight;
          data_d = ~({WIDTH{1'b1}} << weight);
          index_d = '0;
        end
      end
      RUN: begin
        if (abort) state_d = FIN;
        else if (vec_ready) begin
          if (vec_last) state_d = FIN;
          else begin
            data_d = nxt[WIDTH-1:0];
            index_d = index_q + IW'(index_q != '1);
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      data_q <= '0;
      index_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      data_q <= data_d;
      index_q <= index_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_popcount_weight_enum.sv
// tb_popcount_weight_enum: random-backpressure bench against a bit-scanning next-combination model
module tb_popcount_weight_enum;
  localparam int W = 28;
  localparam int CW = 5;
  localparam int IW = 32;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, vec_ready = 0;
  logic [CW-1:0] weight = '0;
  logic busy, done, err, vec_valid, vec_last;
  logic [W-1:0] vec_data;
  logic [IW-1:0] vec_index;
  int n_chk = 0, n_fail = 0;

  popcount_weight_enum #(.WIDTH(W), .CW(CW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .weight(weight), .abort(abort),
    .busy(busy), .done(done), .err(err), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .vec_last(vec_last), .vec_index(vec_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    if (k > n) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // next larger value with equal popcount: move the lowest "01" up, pack the ones below it to bit 0
  function automatic logic [W-1:0] next_ref(input logic [W-1:0] x);
    int ones = 0;
    logic [W-1:0] y = x;
    for (int i = 0; i < W - 1; i++) begin
      if (x[i]) ones++;
      if (x[i] && !x[i+1]) begin
        y[i+1] = 1'b1;
        for (int j = 0; j <= i; j++) y[j] = j < ones - 1;
        return y;
      end
    end
    return y;
  endfunction

  task automatic run(input int k, input int pct, input int abort_at, input bit noise);
    logic [W-1:0] exp_v = '0, last_v = '0, seen;
    int idx = 0, n = 0;
    longint budget;
    bit fin = 0, rdy, ab;
    for (int i = 0; i < k && i < W; i++) begin
      exp_v[i] = 1'b1;
      last_v[W-1-i] = 1'b1;
    end
    budget = 40 * binom(W, k) + 100;
    @(negedge clk); start = 1; weight = CW'(k);
    @(negedge clk); start = 0;
    if (k > W) begin
      chk("err_flag", err, 1);
      chk("err_done", done, 1);
      chk("err_valid", vec_valid, 0);
      @(negedge clk);
      chk("err_done_drop", done, 0);
      chk("err_hold", err, 1);
      chk("err_valid_idle", vec_valid, 0);
      return;
    end
    chk("err_clear", err, 0);
    chk("busy", busy, 1);
    while (!fin) begin
      chk("valid", vec_valid, 1);
      chk("data", vec_data, exp_v);
      chk("index", vec_index, idx);
      chk("last", vec_last, exp_v == last_v);
      seen = vec_data;
      rdy = $urandom_range(99) < pct;
      ab = idx == abort_at;
      vec_ready = rdy; abort = ab;
      start = noise && $urandom_range(7) == 0;
      weight = CW'($urandom);
      @(negedge clk);
      vec_ready = 0; abort = 0; start = 0;
      if (rdy) begin
        chk("popcount", $countones(seen), k);
        n++;
      end
      if (ab || (rdy && exp_v == last_v)) begin
        fin = 1;
        chk("end_valid", vec_valid, 0);
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        @(negedge clk);
        chk("done_once", done, 0);
        chk("idle_busy", busy, 0);
      end else if (rdy) begin
        exp_v = next_ref(exp_v);
        idx++;
      end
      budget--;
      if (budget == 0 && !fin) begin
        chk("timeout", 0, 1);
        fin = 1;
      end
    end
    chk("count", n, abort_at >= 0 ? abort_at + 1 : binom(W, k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int picks[9] = '{0, 1, 2, 26, 27, 28, 29, 30, 31};
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", vec_valid, 0);
    chk("rst_last", vec_last, 0);
    chk("rst_data", vec_data, 0);
    chk("rst_index", vec_index, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run(0, 100, -1, 0);
    run(1, 100, -1, 0);
    run(2, 100, -1, 0);
    run(28, 100, -1, 0);
    run(29, 100, -1, 0);
    run(3, 50, -1, 1);
    run(14, 100, 100, 0);
    @(negedge clk); start = 1; weight = CW'(14);
    @(negedge clk); start = 0; vec_ready = 1;
    repeat (30) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_valid", vec_valid, 0);
    chk("arst_last", vec_last, 0);
    chk("arst_data", vec_data, 0);
    chk("arst_index", vec_index, 0);
    @(negedge clk);
    chk("arst_no_done", done, 0);
    rst_n = 1; vec_ready = 0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    run(1, 100, -1, 0);
    @(negedge clk); abort = 1;
    @(negedge clk); abort = 0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_done", done, 0);
    repeat (8) run(picks[$urandom_range(8)], $urandom_range(20, 100), -1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/popcount_weight_enum.md
Name: popcount_weight_enum

Overview:
- Sequential stimulus generator; the inverse of the popcount encoders.
- Given a target weight k, it emits every WIDTH-bit vector with exactly k ones, one per cycle, in ascending numeric order (Gosper next-combination order).
- Feeds approximate popcount cores under characterisation so that MAE, WCE and EP can be measured per output class without a full 2^WIDTH sweep.
- Sits between the characterisation sequencer and the DUT input register.

Parameters:
- WIDTH, 28, vector width; must match the popcount core input width.
- CW, 5, weight/count width, equal to ceil(log2(WIDTH+1)).
- IW, 32, vector index counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- weight  in  CW  target popcount k; sampled with start.
- abort  in  1  terminates enumeration; acts in RUN only.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at the end of enumeration, at error, or at abort.
- err  out  1  set when weight > WIDTH; cleared by the next accepted start.
- vec_valid  out  1  vec_data holds a valid vector.
- vec_ready  in  1  consumer accepts the vector.
- vec_data  out  WIDTH  current vector.
- vec_last  out  1  qualifies the final vector of the sequence.
- vec_index  out  IW  zero-based ordinal of vec_data within the sequence.

Behaviour:
- Reset values (async on rst_n low): state=IDLE; busy, done, err, vec_valid, vec_last = 0; vec_data = 0; vec_index = 0.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1 and weight <= WIDTH:
  - latch k;
  - load vec_data = (1<<k)-1 and vec_index = 0;
  - move to RUN. vec_valid and busy go high the next cycle, so latency is 1 cycle.
- IDLE, start=1 and weight > WIDTH: err=1; go to FIN; no vectors are emitted.
- RUN, transfer (vec_valid & vec_ready):
  - if vec_last, go to FIN and drop vec_valid;
  - else vec_data <= next(vec_data) and vec_index <= vec_index+1. Valid stays high, giving a throughput of 1 vector/cycle.
- next(x) is computed as:
  - c = x & -x;
  - r = x + c;
  - next = r | (((r ^ x) >> 2) >> ctz(x)).
  - ctz comes from a combinational priority encoder; no divider.
  - All arithmetic is WIDTH+1 bits. The carry-out of r is never set before vec_last.
- vec_last is asserted combinationally when vec_data == ((1<<k)-1) << (WIDTH-k).
  - k=0: the single vector 0 is the last vector.
  - k=WIDTH: the single all-ones vector is the last vector.
- Backpressure: while vec_valid & !vec_ready, vec_data, vec_index and vec_last hold stable. vec_valid never drops without a transfer, except on abort or reset.
- abort in RUN takes priority over a simultaneous transfer. The FSM goes to FIN and vec_valid is 0 the next cycle. The in-flight vector counts as consumed only if ready was high in that same cycle.
- FIN: done=1 for exactly one cycle; busy=0; then IDLE.
- start is ignored in RUN and FIN.
- abort is ignored in IDLE and FIN.
- vec_index saturates at all-ones and does not wrap. It cannot overflow for WIDTH=28, since C(28,14) = 40116600.
- Reset mid-RUN: all outputs return to reset values immediately (asynchronous). No done pulse is generated.
- err holds until the next accepted start; done and err may be observed high together.

Test Plan:
- weight=0, ready=1 → exactly one vector 0x0000000 with vec_last=1, index 0; done pulses 1 cycle after the transfer.
- weight=1, ready=1 → 28 vectors 0x1, 0x2, 0x4 … 0x8000000 on consecutive cycles; vec_last only on 0x8000000 (index 27).
- weight=2 → 378 vectors; first is 0x3, second 0x5, third 0x6; last is 0xC000000 at index 377. Every vector is checked against a reference popcount of 2 and strictly increasing order.
- weight=28 → single vector 0xFFFFFFF with last=1. Separately, weight=29 → err=1, done pulse, vec_valid never asserted.
- weight=3 with random vec_ready (about 50%) → data, index and last stable through stalls; total 3276 transfers with no duplicates or gaps.
- weight=14: assert abort at index 100 with ready=1 → vec_valid low next cycle, done pulses once.
- weight=14: assert rst_n=0 mid-run → all outputs 0 asynchronously, no done pulse; a following start with weight=1 restarts at 0x1.
